// File: rtl/bp_be_dcache_lce_cmd_seq.sv
// bp_be_dcache_lce_cmd_seq
//   LCE-side sequencer. Takes one coherence command at a time and expands it
//   into the tag_mem / data_mem / stat_mem packet sequence the dcache expects.
//   Writebacks return the dirty status and the block data (zero if clean).
//   Optional feature macro: BP_BE_DCACHE_LCE_CMD_SEQ_STATS_EN adds saturating
//   writeback counters on wb_cnt_o / dirty_wb_cnt_o.
module bp_be_dcache_lce_cmd_seq #(
  parameter int unsigned sets_p        = 64,
  parameter int unsigned ways_p        = 8,
  parameter int unsigned ptag_width_p  = 28,
  parameter int unsigned coh_bits_p    = 2,
  parameter int unsigned block_width_p = 512,
  localparam int unsigned idx_w        = (sets_p > 1) ? $clog2(sets_p) : 1,
  localparam int unsigned way_w        = (ways_p > 1) ? $clog2(ways_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic                     cmd_v_i,
  output logic                     cmd_ready_o,
  input  logic [1:0]               cmd_op_i,
  input  logic [idx_w-1:0]         cmd_index_i,
  input  logic [way_w-1:0]         cmd_way_i,
  input  logic [ptag_width_p-1:0]  cmd_tag_i,
  input  logic [coh_bits_p-1:0]    cmd_coh_i,

  output logic                     resp_v_o,
  input  logic                     resp_yumi_i,
  output logic                     resp_dirty_o,
  output logic [block_width_p-1:0] resp_data_o,
`ifdef BP_BE_DCACHE_LCE_CMD_SEQ_STATS_EN
  output logic [15:0]              wb_cnt_o,
  output logic [15:0]              dirty_wb_cnt_o,
`endif

  output logic                     tag_pkt_v_o,
  input  logic                     tag_pkt_yumi_i,
  output logic [1:0]               tag_pkt_op_o,
  output logic                     data_pkt_v_o,
  input  logic                     data_pkt_yumi_i,
  output logic [1:0]               data_pkt_op_o,
  output logic                     stat_pkt_v_o,
  input  logic                     stat_pkt_yumi_i,
  output logic [1:0]               stat_pkt_op_o,

  output logic [idx_w-1:0]         pkt_index_o,
  output logic [way_w-1:0]         pkt_way_o,
  output logic [ptag_width_p-1:0]  pkt_tag_o,
  output logic [coh_bits_p-1:0]    pkt_coh_o,

  input  logic [block_width_p-1:0] data_mem_i,
  input  logic [ways_p-1:0]        stat_dirty_i
);

  // Command opcodes
  localparam logic [1:0] CMD_SET_CLEAR  = 2'd0;
  localparam logic [1:0] CMD_INVALIDATE = 2'd1;
  localparam logic [1:0] CMD_WRITEBACK  = 2'd2;
  localparam logic [1:0] CMD_SET_TAG    = 2'd3;

  // dcache packet opcodes
  localparam logic [1:0] TAG_OP_SET_CLEAR    = 2'd0;
  localparam logic [1:0] TAG_OP_INVALIDATE   = 2'd1;
  localparam logic [1:0] TAG_OP_SET_TAG      = 2'd2;
  localparam logic [1:0] DATA_OP_READ        = 2'd0;
  localparam logic [1:0] STAT_OP_SET_CLEAR   = 2'd0;
  localparam logic [1:0] STAT_OP_READ        = 2'd1;
  localparam logic [1:0] STAT_OP_CLEAR_DIRTY = 2'd2;

  // Sequencer states
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_TAG_CLR   = 4'd1;
  localparam logic [3:0] S_STAT_CLR  = 4'd2;
  localparam logic [3:0] S_TAG_INV   = 4'd3;
  localparam logic [3:0] S_TAG_SET   = 4'd4;
  localparam logic [3:0] S_STAT_RD   = 4'd5;
  localparam logic [3:0] S_STAT_CAP  = 4'd6;
  localparam logic [3:0] S_DATA_RD   = 4'd7;
  localparam logic [3:0] S_DATA_CAP  = 4'd8;
  localparam logic [3:0] S_CLR_DIRTY = 4'd9;
  localparam logic [3:0] S_RESP      = 4'd10;

  logic [3:0]               state_q, state_d;
  logic [idx_w-1:0]         index_q;
  logic [way_w-1:0]         way_q;
  logic [ptag_width_p-1:0]  tag_q;
  logic [coh_bits_p-1:0]    coh_q;
  logic                     dirty_q;
  logic [block_width_p-1:0] data_q;
  logic                     cmd_accept;
  logic                     way_dirty;

  assign cmd_ready_o = (state_q == S_IDLE) && !reset_i;
  assign cmd_accept  = cmd_v_i && cmd_ready_o;
  assign way_dirty   = stat_dirty_i[way_q];

  assign pkt_index_o  = index_q;
  assign pkt_way_o    = way_q;
  assign pkt_tag_o    = tag_q;
  assign pkt_coh_o    = coh_q;
  assign resp_dirty_o = dirty_q;
  assign resp_data_o  = data_q;

  // Next-state: each packet state advances only on its own yumi
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_accept) begin
          case (cmd_op_i)
            CMD_SET_CLEAR:  state_d = S_TAG_CLR;
            CMD_INVALIDATE: state_d = S_TAG_INV;
            CMD_WRITEBACK:  state_d = S_STAT_RD;
            CMD_SET_TAG:    state_d = S_TAG_SET;
            default:        state_d = S_IDLE;
          endcase
        end
      end
      S_TAG_CLR:   if (tag_pkt_yumi_i)  state_d = S_STAT_CLR;
      S_STAT_CLR:  if (stat_pkt_yumi_i) state_d = S_IDLE;
      S_TAG_INV:   if (tag_pkt_yumi_i)  state_d = S_IDLE;
      S_TAG_SET:   if (tag_pkt_yumi_i)  state_d = S_IDLE;
      S_STAT_RD:   if (stat_pkt_yumi_i) state_d = S_STAT_CAP;
      S_STAT_CAP:  state_d = way_dirty ? S_DATA_RD : S_RESP;
      S_DATA_RD:   if (data_pkt_yumi_i) state_d = S_DATA_CAP;
      S_DATA_CAP:  state_d = S_CLR_DIRTY;
      S_CLR_DIRTY: if (stat_pkt_yumi_i) state_d = S_RESP;
      S_RESP:      if (resp_yumi_i)     state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Packet/response valids and opcodes decoded from state; forced low in reset
  always_comb begin
    tag_pkt_v_o   = 1'b0;
    tag_pkt_op_o  = TAG_OP_SET_CLEAR;
    data_pkt_v_o  = 1'b0;
    data_pkt_op_o = DATA_OP_READ;
    stat_pkt_v_o  = 1'b0;
    stat_pkt_op_o = STAT_OP_SET_CLEAR;
    resp_v_o      = 1'b0;
    if (!reset_i) begin
      case (state_q)
        S_TAG_CLR: begin
          tag_pkt_v_o  = 1'b1;
          tag_pkt_op_o = TAG_OP_SET_CLEAR;
        end
        S_STAT_CLR: begin
          stat_pkt_v_o  = 1'b1;
          stat_pkt_op_o = STAT_OP_SET_CLEAR;
        end
        S_TAG_INV: begin
          tag_pkt_v_o  = 1'b1;
          tag_pkt_op_o = TAG_OP_INVALIDATE;
        end
        S_TAG_SET: begin
          tag_pkt_v_o  = 1'b1;
          tag_pkt_op_o = TAG_OP_SET_TAG;
        end
        S_STAT_RD: begin
          stat_pkt_v_o  = 1'b1;
          stat_pkt_op_o = STAT_OP_READ;
        end
        S_DATA_RD: begin
          data_pkt_v_o  = 1'b1;
          data_pkt_op_o = DATA_OP_READ;
        end
        S_CLR_DIRTY: begin
          stat_pkt_v_o  = 1'b1;
          stat_pkt_op_o = STAT_OP_CLEAR_DIRTY;
        end
        S_RESP: resp_v_o = 1'b1;
        default: ;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Latch the command fields on acceptance; they drive the shared packet fields
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      index_q <= '0;
      way_q   <= '0;
      tag_q   <= '0;
      coh_q   <= '0;
    end else if (cmd_accept) begin
      index_q <= cmd_index_i;
      way_q   <= cmd_way_i;
      tag_q   <= cmd_tag_i;
      coh_q   <= cmd_coh_i;
    end
  end

  // Capture dirty bit and block data for the writeback response
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dirty_q <= 1'b0;
      data_q  <= '0;
    end else if (state_q == S_STAT_CAP) begin
      dirty_q <= way_dirty;
      if (!way_dirty) data_q <= '0;
    end else if (state_q == S_DATA_CAP) begin
      data_q <= data_mem_i;
    end
  end

`ifdef BP_BE_DCACHE_LCE_CMD_SEQ_STATS_EN
  logic [15:0] wb_cnt_q;
  logic [15:0] dirty_wb_cnt_q;
  logic        resp_fire;

  assign resp_fire      = resp_v_o && resp_yumi_i;
  assign wb_cnt_o       = wb_cnt_q;
  assign dirty_wb_cnt_o = dirty_wb_cnt_q;

  // Saturating writeback counters, stepped on each response handshake
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wb_cnt_q       <= '0;
      dirty_wb_cnt_q <= '0;
    end else if (resp_fire) begin
      if (wb_cnt_q != 16'hFFFF) wb_cnt_q <= wb_cnt_q + 16'd1;
      if (dirty_q && (dirty_wb_cnt_q != 16'hFFFF))
        dirty_wb_cnt_q <= dirty_wb_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_be_dcache_lce_cmd_seq.sv
// Directed testbench for bp_be_dcache_lce_cmd_seq.
module tb_bp_be_dcache_lce_cmd_seq;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         cmd_v_i;
  logic         cmd_ready_o;
  logic [1:0]   cmd_op_i;
  logic [5:0]   cmd_index_i;
  logic [2:0]   cmd_way_i;
  logic [27:0]  cmd_tag_i;
  logic [1:0]   cmd_coh_i;
  logic         resp_v_o;
  logic         resp_yumi_i;
  logic         resp_dirty_o;
  logic [511:0] resp_data_o;
`ifdef BP_BE_DCACHE_LCE_CMD_SEQ_STATS_EN
  logic [15:0]  wb_cnt_o;
  logic [15:0]  dirty_wb_cnt_o;
`endif
  logic         tag_pkt_v_o, tag_pkt_yumi_i;
  logic [1:0]   tag_pkt_op_o;
  logic         data_pkt_v_o, data_pkt_yumi_i;
  logic [1:0]   data_pkt_op_o;
  logic         stat_pkt_v_o, stat_pkt_yumi_i;
  logic [1:0]   stat_pkt_op_o;
  logic [5:0]   pkt_index_o;
  logic [2:0]   pkt_way_o;
  logic [27:0]  pkt_tag_o;
  logic [1:0]   pkt_coh_o;
  logic [511:0] data_mem_i;
  logic [7:0]   stat_dirty_i;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned onehot_err = 0;
  logic [3:0]  pkt_q[$];

  // Packet codes: {channel, op}; channel tag=1, data=2, stat=3
  localparam logic [3:0] P_TAG_CLR  = 4'b01_00;
  localparam logic [3:0] P_TAG_INV  = 4'b01_01;
  localparam logic [3:0] P_TAG_SET  = 4'b01_10;
  localparam logic [3:0] P_DATA_RD  = 4'b10_00;
  localparam logic [3:0] P_STAT_CLR = 4'b11_00;
  localparam logic [3:0] P_STAT_RD  = 4'b11_01;
  localparam logic [3:0] P_STAT_CD  = 4'b11_10;

  bp_be_dcache_lce_cmd_seq #(
    .sets_p(64), .ways_p(8), .ptag_width_p(28), .coh_bits_p(2), .block_width_p(512)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_index_i(cmd_index_i), .cmd_way_i(cmd_way_i), .cmd_tag_i(cmd_tag_i),
    .cmd_coh_i(cmd_coh_i),
    .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i), .resp_dirty_o(resp_dirty_o),
    .resp_data_o(resp_data_o),
`ifdef BP_BE_DCACHE_LCE_CMD_SEQ_STATS_EN
    .wb_cnt_o(wb_cnt_o), .dirty_wb_cnt_o(dirty_wb_cnt_o),
`endif
    .tag_pkt_v_o(tag_pkt_v_o), .tag_pkt_yumi_i(tag_pkt_yumi_i), .tag_pkt_op_o(tag_pkt_op_o),
    .data_pkt_v_o(data_pkt_v_o), .data_pkt_yumi_i(data_pkt_yumi_i), .data_pkt_op_o(data_pkt_op_o),
    .stat_pkt_v_o(stat_pkt_v_o), .stat_pkt_yumi_i(stat_pkt_yumi_i), .stat_pkt_op_o(stat_pkt_op_o),
    .pkt_index_o(pkt_index_o), .pkt_way_o(pkt_way_o), .pkt_tag_o(pkt_tag_o),
    .pkt_coh_o(pkt_coh_o),
    .data_mem_i(data_mem_i), .stat_dirty_i(stat_dirty_i)
  );

  always #5 clk = ~clk;

  // Record every packet handshake and flag cycles with more than one packet valid
  always @(negedge clk) begin
    if (tag_pkt_v_o && tag_pkt_yumi_i)   pkt_q.push_back({2'd1, tag_pkt_op_o});
    if (data_pkt_v_o && data_pkt_yumi_i) pkt_q.push_back({2'd2, data_pkt_op_o});
    if (stat_pkt_v_o && stat_pkt_yumi_i) pkt_q.push_back({2'd3, stat_pkt_op_o});
    if ((32'(tag_pkt_v_o) + 32'(data_pkt_v_o) + 32'(stat_pkt_v_o)) > 32'd1)
      onehot_err++;
  end

  task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {count, first four packet codes}
  function automatic logic [19:0] pack_q();
    logic [19:0] v;
    v = '0;
    v[19:16] = 4'(pkt_q.size());
    for (int i = 0; i < 4; i++)
      if (i < pkt_q.size()) v[15-4*i -: 4] = pkt_q[i];
    return v;
  endfunction

  task automatic send_cmd(input logic [1:0] op, input logic [5:0] idx, input logic [2:0] way,
                          input logic [27:0] tg, input logic [1:0] coh);
    cmd_v_i = 1'b1; cmd_op_i = op; cmd_index_i = idx; cmd_way_i = way;
    cmd_tag_i = tg; cmd_coh_i = coh;
    check_val("ready_before_accept", 512'(cmd_ready_o), 512'd1);
    tick();
    cmd_v_i = 1'b0; cmd_op_i = 2'd0; cmd_index_i = '0; cmd_way_i = '0;
    cmd_tag_i = '0; cmd_coh_i = '0;
  endtask

  task automatic do_wb(input logic [5:0] idx, input logic [2:0] way, input logic [7:0] dvec,
                       input logic exp_dirty, input int unsigned exp_lat);
    int unsigned k;
    pkt_q.delete();
    stat_dirty_i = dvec;
    resp_yumi_i  = 1'b0;
    send_cmd(2'd2, idx, way, 28'd0, 2'd0);
    k = 0;
    while (!resp_v_o && k < 20) begin
      tick();
      k++;
    end
    check_val("wb_resp_latency", 512'(k), 512'(exp_lat));
    check_val("wb_resp_dirty", 512'(resp_dirty_o), 512'(exp_dirty));
    check_val("wb_resp_data", resp_data_o, exp_dirty ? {64{8'hA5}} : 512'd0);
    resp_yumi_i = 1'b1;
    tick();
    resp_yumi_i = 1'b0;
    check_val("wb_resp_dropped", 512'(resp_v_o), 512'd0);
    check_val("wb_ready_after", 512'(cmd_ready_o), 512'd1);
    if (exp_dirty)
      check_val("wb_pkt_seq", 512'(pack_q()), 512'({4'd3, P_STAT_RD, P_DATA_RD, P_STAT_CD, 4'd0}));
    else
      check_val("wb_pkt_seq", 512'(pack_q()), 512'({4'd1, P_STAT_RD, 12'd0}));
  endtask

  initial begin
    reset_i = 1'b1; cmd_v_i = 1'b0; cmd_op_i = '0; cmd_index_i = '0; cmd_way_i = '0;
    cmd_tag_i = '0; cmd_coh_i = '0; resp_yumi_i = 1'b0;
    tag_pkt_yumi_i = 1'b1; data_pkt_yumi_i = 1'b1; stat_pkt_yumi_i = 1'b1;
    data_mem_i = {64{8'hA5}}; stat_dirty_i = '0;

    // Reset state
    tick(); tick();
    check_val("rst_ready", 512'(cmd_ready_o), 512'd0);
    check_val("rst_valids", 512'({tag_pkt_v_o, data_pkt_v_o, stat_pkt_v_o, resp_v_o}), 512'd0);
    check_val("rst_resp", 512'({resp_dirty_o, resp_data_o[510:0]}), 512'd0);
    check_val("rst_fields", 512'({pkt_index_o, pkt_way_o, pkt_tag_o, pkt_coh_o}), 512'd0);
    reset_i = 1'b0;
    #1;
    check_val("idle_ready", 512'(cmd_ready_o), 512'd1);

    // set_clear idx 5
    pkt_q.delete();
    send_cmd(2'd0, 6'd5, 3'd0, 28'd0, 2'd0);
    check_val("sc_tag_pkt", 512'({tag_pkt_v_o, tag_pkt_op_o, pkt_index_o}), 512'({1'b1, 2'd0, 6'd5}));
    check_val("sc_ready_busy", 512'(cmd_ready_o), 512'd0);
    tick();
    check_val("sc_stat_pkt", 512'({stat_pkt_v_o, stat_pkt_op_o, pkt_index_o}), 512'({1'b1, 2'd0, 6'd5}));
    tick();
    check_val("sc_ready_done", 512'(cmd_ready_o), 512'd1);
    check_val("sc_pkt_seq", 512'(pack_q()), 512'({4'd2, P_TAG_CLR, P_STAT_CLR, 8'd0}));

    // invalidate idx 3 way 2 with tag yumi stalled for 4 cycles
    pkt_q.delete();
    tag_pkt_yumi_i = 1'b0;
    send_cmd(2'd1, 6'd3, 3'd2, 28'd0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      check_val("inv_hold", 512'({tag_pkt_v_o, tag_pkt_op_o, pkt_index_o, pkt_way_o}),
                512'({1'b1, 2'd1, 6'd3, 3'd2}));
      tick();
    end
    tag_pkt_yumi_i = 1'b1;
    check_val("inv_last", 512'({tag_pkt_v_o, tag_pkt_op_o, pkt_index_o, pkt_way_o}),
              512'({1'b1, 2'd1, 6'd3, 3'd2}));
    tick();
    check_val("inv_done", 512'({tag_pkt_v_o, cmd_ready_o}), 512'({1'b0, 1'b1}));
    check_val("inv_pkt_seq", 512'(pack_q()), 512'({4'd1, P_TAG_INV, 12'd0}));

    // set_tag idx 9 way 6
    pkt_q.delete();
    send_cmd(2'd3, 6'd9, 3'd6, 28'hABCDEF1, 2'd2);
    check_val("st_pkt", 512'({tag_pkt_v_o, tag_pkt_op_o, pkt_index_o, pkt_way_o, pkt_tag_o, pkt_coh_o}),
              512'({1'b1, 2'd2, 6'd9, 3'd6, 28'hABCDEF1, 2'd2}));
    tick();
    check_val("st_done", 512'(cmd_ready_o), 512'd1);
    check_val("st_pkt_seq", 512'(pack_q()), 512'({4'd1, P_TAG_SET, 12'd0}));

    // writebacks: dirty way 1, clean with all-zero vector, clean way 4 among dirty neighbours
    do_wb(6'd7, 3'd1, 8'b0000_0010, 1'b1, 5);
    do_wb(6'd8, 3'd3, 8'b0000_0000, 1'b0, 2);
    do_wb(6'd2, 3'd4, 8'b1110_1111, 1'b0, 2);

    // reset asserted while in DATA_RD
    pkt_q.delete();
    stat_dirty_i = 8'b0000_0010;
    data_pkt_yumi_i = 1'b0;
    send_cmd(2'd2, 6'd7, 3'd1, 28'd0, 2'd0);
    tick(); tick();
    check_val("rr_in_data_rd", 512'(data_pkt_v_o), 512'd1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    data_pkt_yumi_i = 1'b1;
    #1;
    check_val("rr_valids", 512'({tag_pkt_v_o, data_pkt_v_o, stat_pkt_v_o, resp_v_o}), 512'd0);
    check_val("rr_idle", 512'(cmd_ready_o), 512'd1);
    tick(); tick(); tick();
    check_val("rr_no_clear_dirty", 512'(pack_q()), 512'({4'd1, P_STAT_RD, 12'd0}));

`ifdef BP_BE_DCACHE_LCE_CMD_SEQ_STATS_EN
    check_val("cnt_after_reset", 512'({wb_cnt_o, dirty_wb_cnt_o}), 512'd0);
    do_wb(6'd1, 3'd0, 8'b0000_0001, 1'b1, 5);
    do_wb(6'd2, 3'd0, 8'b0000_0000, 1'b0, 2);
    do_wb(6'd3, 3'd5, 8'b0010_0000, 1'b1, 5);
    check_val("wb_cnt", 512'(wb_cnt_o), 512'd3);
    check_val("dirty_wb_cnt", 512'(dirty_wb_cnt_o), 512'd2);
    dut.wb_cnt_q = 16'hFFFF;
    dut.dirty_wb_cnt_q = 16'hFFFF;
    do_wb(6'd4, 3'd2, 8'b0000_0100, 1'b1, 5);
    check_val("wb_cnt_sat", 512'(wb_cnt_o), 512'h0FFFF);
    check_val("dirty_wb_cnt_sat", 512'(dirty_wb_cnt_o), 512'h0FFFF);
`endif

    check_val("one_hot_valids", 512'(onehot_err), 512'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
